// File: rtl/weight_fifo_pkg.sv
// Shared defaults and helpers for the multi-lane weight FIFO.
package weight_fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefLanes     = 4;
  localparam int unsigned DefDepth     = 8;

  // LSB position of a lane inside a packed row.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_lane_delay.sv
// Fixed-length {valid,data} shift chain with synchronous reset; STAGES=0 is a plain wire.
module weight_lane_delay #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_chain
    logic [DATA_WIDTH:0] chain_q [STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
      end else begin
        chain_q[0] <= {in_valid, in_data};
        for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
      end
    end

    assign {out_valid, out_data} = chain_q[STAGES-1];
  end

endmodule

// File: rtl/weight_lane_fifo.sv
// Multi-lane weight row FIFO with registered read, occupancy and handshake flags.
// Optional per-lane diagonal skew of the read side: WEIGHT_LANE_FIFO_SKEW_EN.
module weight_lane_fifo
  import weight_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LANES      = DefLanes,
  parameter int unsigned DEPTH      = DefDepth,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                        rd_en,
  output logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic [LANES-1:0]            rd_valid,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned RowW = LANES * DATA_WIDTH;
  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [RowW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RowW-1:0]  rd_data_q;
  logic             rd_valid_q, overflow_q, underflow_q;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop_ok;
      overflow_q  <= wr_en && !push_ok;
      underflow_q <= rd_en && !pop_ok;
      if (pop_ok) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage has no reset; rows are only ever read after being written.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef WEIGHT_LANE_FIFO_SKEW_EN
  for (genvar i = 0; i < int'(LANES); i++) begin : g_skew
    weight_lane_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .STAGES    (i)
    ) u_delay (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_valid_q),
      .in_data  (rd_data_q[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .out_valid(rd_valid[i]),
      .out_data (rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = {LANES{rd_valid_q}};
`endif

endmodule
